// File: rtl/reg_list_sequencer_pkg.sv
// reg_list_sequencer_pkg: shared types and constants for the register-list micro-op sequencer.
package reg_list_sequencer_pkg;
    localparam int LIST_WIDTH = 9;
    localparam int ADDR_WIDTH = 4;
    localparam int WORD = 32;
    localparam int IDX_WIDTH = $clog2(LIST_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] SP_ADDR = 4'd13;
    localparam logic [ADDR_WIDTH-1:0] LR_ADDR = 4'd14;
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = 4'd15;
    typedef enum logic [1:0] {PUSH, POP, LDM, STM} list_op_t;
    typedef enum logic [1:0] {IDLE, ISSUE, BASE_WB} seq_state_t;
endpackage

// File: rtl/reg_list_sequencer_if.sv
// reg_list_sequencer_if: decode-side request and micro-op output bundle of the sequencer.
interface reg_list_sequencer_if;
    import reg_list_sequencer_pkg::*;
    logic is_valid_i;
    logic start_i;
    list_op_t op_i;
    logic [LIST_WIDTH-1:0] reg_list_i;
    logic [ADDR_WIDTH-1:0] base_reg_i;
    logic hold_i;
    logic flush_pipeline_i;
    logic stall_pipeline_o;
    logic uop_valid_o;
    logic [ADDR_WIDTH-1:0] uop_reg_addr_o;
    logic [ADDR_WIDTH-1:0] uop_base_addr_o;
    logic [WORD-1:0] uop_offset_o;
    logic uop_mem_read_o;
    logic uop_mem_write_o;
    logic uop_base_wb_o;
    logic uop_pc_load_o;
    logic last_uop_o;
    modport slave (
        input  is_valid_i, start_i, op_i, reg_list_i, base_reg_i, hold_i, flush_pipeline_i,
        output stall_pipeline_o, uop_valid_o, uop_reg_addr_o, uop_base_addr_o, uop_offset_o,
               uop_mem_read_o, uop_mem_write_o, uop_base_wb_o, uop_pc_load_o, last_uop_o
    );
    modport master (
        output is_valid_i, start_i, op_i, reg_list_i, base_reg_i, hold_i, flush_pipeline_i,
        input  stall_pipeline_o, uop_valid_o, uop_reg_addr_o, uop_base_addr_o, uop_offset_o,
               uop_mem_read_o, uop_mem_write_o, uop_base_wb_o, uop_pc_load_o, last_uop_o
    );
endinterface

// File: rtl/reg_list_priority_enc.sv
// reg_list_priority_enc: index of the lowest set bit of a register list.
module reg_list_priority_enc
    import reg_list_sequencer_pkg::*;
#(
    parameter int W = LIST_WIDTH
) (
    input  logic [W-1:0]         req_i,
    output logic [$clog2(W)-1:0] index_o,
    output logic                 any_set_o
);
    localparam int IW = $clog2(W);
    always_comb begin
        index_o = '0;
        for (int i = W - 1; i >= 0; i--) index_o = req_i[i] ? IW'(i) : index_o;
    end
    assign any_set_o = |req_i;
endmodule

// File: rtl/reg_list_sequencer.sv
// reg_list_sequencer: expands PUSH/POP/LDMIA/STMIA into one transfer micro-op per
// register (ascending, bit 8 last) followed by one base-writeback micro-op.
module reg_list_sequencer
    import reg_list_sequencer_pkg::*;
(
    input logic clk_i,
    input logic reset_i,
    reg_list_sequencer_if.slave bus
);
    seq_state_t state_q;
    list_op_t op_q;
    logic [LIST_WIDTH-1:0] rem_q, list_m, rem_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [WORD-1:0] off_q, n4_q, n4;
    logic [3:0] n;
    logic [IDX_WIDTH-1:0] idx;
    logic sup_q, accept, issue, any_set;

    reg_list_priority_enc #(.W(LIST_WIDTH)) u_enc (.req_i(rem_q), .index_o(idx), .any_set_o(any_set));

    // Bit 8 only means LR/PC for PUSH/POP; LDM/STM address R0..R7 only.
    always_comb begin
        list_m = bus.reg_list_i;
        list_m[LIST_WIDTH-1] = list_m[LIST_WIDTH-1] & (bus.op_i inside {PUSH, POP});
        n = '0;
        for (int i = 0; i < LIST_WIDTH; i++) n = n + 4'(list_m[i]);
    end

    assign n4 = WORD'({n, 2'b00});
    assign rem_nxt = rem_q & (rem_q - LIST_WIDTH'(1));
    assign accept = state_q == IDLE && bus.is_valid_i && bus.start_i && !bus.flush_pipeline_i && !bus.hold_i;
    assign issue = state_q == ISSUE && any_set;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            op_q <= PUSH;
            rem_q <= '0;
            base_q <= '0;
            off_q <= '0;
            n4_q <= '0;
            sup_q <= 1'b0;
        end else if (bus.flush_pipeline_i) begin
            state_q <= IDLE;
            rem_q <= '0;
            off_q <= '0;
        end else if (accept) begin
            state_q <= list_m == '0 ? BASE_WB : ISSUE;
            op_q <= bus.op_i;
            rem_q <= list_m;
            n4_q <= n4;
            base_q <= bus.op_i inside {PUSH, POP} ? SP_ADDR : bus.base_reg_i;
            off_q <= bus.op_i == PUSH ? -n4 : '0;
            sup_q <= bus.op_i == LDM && !bus.base_reg_i[3] && list_m[bus.base_reg_i[2:0]];
        end else if (!bus.hold_i) begin
            if (state_q == ISSUE) begin
                rem_q <= rem_nxt;
                off_q <= rem_nxt == '0 ? (op_q == PUSH ? -n4_q : n4_q) : off_q + WORD'(4);
                state_q <= rem_nxt == '0 ? BASE_WB : ISSUE;
            end else if (state_q == BASE_WB) begin
                state_q <= IDLE;
            end
        end
    end

    assign bus.stall_pipeline_o = (state_q == IDLE && bus.is_valid_i && bus.start_i) || state_q == ISSUE;
    assign bus.uop_valid_o = state_q != IDLE;
    assign bus.uop_reg_addr_o = !issue ? '0
                              : idx == IDX_WIDTH'(LIST_WIDTH - 1) ? (op_q == PUSH ? LR_ADDR : PC_ADDR)
                              : ADDR_WIDTH'(idx);
    assign bus.uop_base_addr_o = bus.uop_valid_o ? base_q : '0;
    assign bus.uop_offset_o = bus.uop_valid_o ? off_q : '0;
    assign bus.uop_mem_read_o = issue && op_q inside {POP, LDM};
    assign bus.uop_mem_write_o = issue && op_q inside {PUSH, STM};
    assign bus.uop_base_wb_o = state_q == BASE_WB && !sup_q;
    assign bus.uop_pc_load_o = issue && op_q == POP && idx == IDX_WIDTH'(LIST_WIDTH - 1);
    assign bus.last_uop_o = state_q == BASE_WB;
endmodule

// File: doc/reg_list_sequencer.md
Name: reg_list_sequencer

Overview:
Micro-op sequencer for Thumb register-list instructions: PUSH, POP, LDMIA and STMIA. It sits in the decode stage beside the controller and hazard detector. It takes one decoded register-list instruction and stalls fetch/decode while it runs. It emits one register transfer micro-op per cycle toward the decode/execute register, then one base-writeback micro-op.

Parameters:
LIST_WIDTH, 9, register-list width; bits 7:0 = R0..R7, bit 8 = LR (PUSH) or PC (POP).
ADDR_WIDTH, 4, register address width; value comes from the shared package.
WORD, 32, datapath width; value comes from the shared package.

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; asynchronous, active-high
is_valid_i  in  1  decode-stage instruction is valid
start_i  in  1  decoded instruction is a register-list op
op_i  in  2  list_op_t: PUSH=0, POP=1, LDM=2, STM=3
reg_list_i  in  LIST_WIDTH  register list
base_reg_i  in  ADDR_WIDTH  base register for LDM/STM; ignored for PUSH/POP (SP=13 used)
hold_i  in  1  downstream hazard stall; freeze all state
flush_pipeline_i  in  1  abort the sequence
stall_pipeline_o  out  1  hold fetch and decode
uop_valid_o  out  1  micro-op fields valid this cycle
uop_reg_addr_o  out  ADDR_WIDTH  register transferred
uop_base_addr_o  out  ADDR_WIDTH  base register
uop_offset_o  out  WORD  byte offset from the original base, two's complement
uop_mem_read_o  out  1  load micro-op
uop_mem_write_o  out  1  store micro-op
uop_base_wb_o  out  1  base-writeback micro-op
uop_pc_load_o  out  1  load targets PC; drives branch_from_wb downstream
last_uop_o  out  1  final micro-op of the sequence

Behaviour:
- Reset: state=IDLE, remaining=0, offset=0.
- Reset outputs: all registered outputs 0; stall_pipeline_o=0.
- States: IDLE, ISSUE, BASE_WB.
- IDLE: if is_valid_i & start_i & !flush_pipeline_i, latch the following, then go to ISSUE (or BASE_WB if the list is empty):
  - op_i, reg_list_i (bit 8 masked to 0 for LDM/STM), base (13 for PUSH/POP, else base_reg_i);
  - N = popcount of the masked list;
  - start offset = -4N for PUSH, 0 otherwise.
- Stall: stall_pipeline_o = (IDLE & is_valid_i & start_i) | ISSUE. It is combinational and is low in BASE_WB, so decode advances on the edge after BASE_WB.
- ISSUE, one micro-op per cycle:
  - lowest set bit k of remaining; uop_reg_addr_o = k for k<8, 14 for PUSH bit 8, 15 for POP bit 8;
  - uop_offset_o = current offset;
  - mem_read for POP/LDM, mem_write for PUSH/STM;
  - uop_pc_load_o = POP & k==8.
  - Next edge: clear bit k, offset += 4. When remaining becomes 0, go to BASE_WB.
- Ordering: ascending register number, bit 8 last. Latency = N+1 cycles after the accept edge.
- BASE_WB: one micro-op with uop_base_wb_o=1, last_uop_o=1, no memory enables.
  - Offset = -4N for PUSH, +4N otherwise.
  - LDM with base in the list: uop_valid_o=1 but uop_base_wb_o=0 (writeback suppressed).
  - Next state: IDLE. start_i is ignored outside IDLE (the same instruction is still in decode during BASE_WB).
- Empty list: go directly to BASE_WB with offset 0; stall is asserted for the accept cycle only.
- Single-register list: ISSUE lasts 1 cycle, then BASE_WB.
- hold_i=1 (ISSUE/BASE_WB): state, remaining, offset and outputs are held; stall stays asserted in ISSUE.
- hold_i in IDLE: acceptance is still blocked, since the decode instruction is also held.
- flush_pipeline_i: highest priority, above hold_i and start_i.
  - Next edge: state=IDLE, remaining=0, all uop outputs 0.
  - A micro-op already presented in the flush cycle is invalidated downstream by the flush.
- Reset mid-sequence: immediate return to reset values (asynchronous).
- Offset arithmetic: WORD-bit two's complement; 4N is at most 36, so no overflow.

Decomposition:
- Shared package (alongside the existing typedefs):
  - list_op_t enum;
  - seq_state_t enum {IDLE, ISSUE, BASE_WB};
  - constants SP_ADDR=13, LR_ADDR=14, PC_ADDR=15.
- One sub-module, reg_list_priority_enc: combinational lowest-set-bit finder over LIST_WIDTH bits; outputs index and any_set.
- Popcount stays inline.

Test Plan:
- PUSH {R0,R2,LR} with hold_i=0:
  - stall high for 4 cycles (accept cycle + 3 ISSUE cycles);
  - micro-ops (reg, offset): (0,-12), (2,-8), (14,-4), all mem_write;
  - BASE_WB: base 13, offset -12, last_uop_o=1, stall low.
- POP {R1,PC}:
  - micro-ops (1,0), (15,4) with uop_pc_load_o=1 only on the second;
  - BASE_WB offset +8.
- LDM R3!,{R3,R4}:
  - loads at offsets 0 and 4;
  - BASE_WB cycle: uop_valid_o=1, uop_base_wb_o=0.
- STM R5!,{R0..R7} with hold_i pulsed 2 cycles during the 3rd micro-op:
  - R2 micro-op held 3 cycles in total;
  - 8 stores at offsets 0..28, then writeback +32;
  - total stall cycles = 1+8+2.
- flush_pipeline_i asserted during PUSH {R0..R7} at the 4th micro-op:
  - next cycle: IDLE, uop_valid_o=0, stall low;
  - a new POP {R0} then starts cleanly.
- Empty list PUSH {}:
  - a single BASE_WB micro-op, offset 0;
  - stall asserted for 1 cycle only.
- Reset asserted mid-sequence with no clock edge: all outputs go to 0 immediately.
